// File: rtl/rob_tag_scheduler_if.sv
// Dispatch/writeback/retire bundle for the reorder-buffer tag scheduler.
// The master side is the front end; the slave side is the scheduler itself.
interface rob_tag_scheduler_if;
   logic       alloc1;
   logic       alloc2;
   logic [4:0] dest1;
   logic [4:0] dest2;
   logic       regwr1;
   logic       regwr2;
   logic       hold;
   logic       flush;
   logic [3:0] wb_valid;
   logic [4:0] wb_tag0;
   logic [4:0] wb_tag1;
   logic [4:0] wb_tag2;
   logic [4:0] wb_tag3;

   logic [4:0] tag1;
   logic [4:0] tag2;
   logic       stall;
   logic       retire1;
   logic       retire2;
   logic       commit1;
   logic       commit2;
   logic [4:0] commit1_addr;
   logic [4:0] commit2_addr;
   logic [4:0] commit1_tag;
   logic [4:0] commit2_tag;
   logic [5:0] count;

   modport master (
      output alloc1, alloc2, dest1, dest2, regwr1, regwr2, hold, flush,
             wb_valid, wb_tag0, wb_tag1, wb_tag2, wb_tag3,
      input  tag1, tag2, stall, retire1, retire2, commit1, commit2,
             commit1_addr, commit2_addr, commit1_tag, commit2_tag, count
   );

   modport slave (
      input  alloc1, alloc2, dest1, dest2, regwr1, regwr2, hold, flush,
             wb_valid, wb_tag0, wb_tag1, wb_tag2, wb_tag3,
      output tag1, tag2, stall, retire1, retire2, commit1, commit2,
             commit1_addr, commit2_addr, commit1_tag, commit2_tag, count
   );
endinterface

// File: rtl/rob_tag_scheduler.sv
// 32-entry reorder buffer tracking tags for a dual-issue front end:
// allocates up to two tags per cycle, marks writebacks done, retires in order.
module rob_tag_scheduler (
   input logic                 clk,
   input logic                 rst,
   rob_tag_scheduler_if.slave  bus
);

   logic [31:0] valid;
   logic [31:0] done;
   logic [31:0] regwr;
   logic [4:0]  dest [32];
   logic [4:0]  head;
   logic [4:0]  tail;
   logic [5:0]  count;

   logic [4:0]  head_next1;
   logic [4:0]  tail_next1;
   logic        do_alloc1;
   logic        do_alloc2;
   logic        ret1;
   logic        ret2;
   logic [1:0]  alloc_num;
   logic [1:0]  retire_num;
   logic [4:0]  wb_tag [4];

   assign wb_tag[0] = bus.wb_tag0;
   assign wb_tag[1] = bus.wb_tag1;
   assign wb_tag[2] = bus.wb_tag2;
   assign wb_tag[3] = bus.wb_tag3;

   assign head_next1 = head + 5'd1;
   assign tail_next1 = tail + 5'd1;

   assign bus.tag1  = tail;
   assign bus.tag2  = tail_next1;
   // Stall looks only at registered occupancy so it never depends on this cycle's retirements.
   assign bus.stall = bus.hold | (count > 6'd30);
   assign bus.count = count;

   assign do_alloc1 = bus.alloc1 & ~bus.stall & ~bus.flush;
   assign do_alloc2 = do_alloc1 & bus.alloc2;

   assign ret1 = ~bus.flush & valid[head] & done[head];
   assign ret2 = ret1 & valid[head_next1] & done[head_next1];

   assign alloc_num  = {1'b0, do_alloc1} + {1'b0, do_alloc2};
   assign retire_num = {1'b0, ret1} + {1'b0, ret2};

   assign bus.retire1      = ret1;
   assign bus.retire2      = ret2;
   assign bus.commit1      = ret1 & regwr[head] & (dest[head] != 5'd0);
   assign bus.commit2      = ret2 & regwr[head_next1] & (dest[head_next1] != 5'd0);
   // Address/tag are zeroed when the slot is not retiring so idle outputs stay quiet.
   assign bus.commit1_addr = ret1 ? dest[head] : 5'd0;
   assign bus.commit2_addr = ret2 ? dest[head_next1] : 5'd0;
   assign bus.commit1_tag  = ret1 ? head : 5'd0;
   assign bus.commit2_tag  = ret2 ? head_next1 : 5'd0;

   // Later writes win: writeback, then retirement clear, then fresh allocation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         done  <= '0;
         regwr <= '0;
         for (int i = 0; i < 32; i++) dest[i] <= 5'd0;
         head  <= 5'd0;
         tail  <= 5'd0;
         count <= 6'd0;
      end else if (bus.flush) begin
         valid <= '0;
         done  <= '0;
         head  <= 5'd0;
         tail  <= 5'd0;
         count <= 6'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (bus.wb_valid[k] && valid[wb_tag[k]]) done[wb_tag[k]] <= 1'b1;
         end
         if (ret1) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
         end
         if (ret2) begin
            valid[head_next1] <= 1'b0;
            done[head_next1]  <= 1'b0;
         end
         if (do_alloc1) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            dest[tail]  <= bus.dest1;
            regwr[tail] <= bus.regwr1;
         end
         if (do_alloc2) begin
            valid[tail_next1] <= 1'b1;
            done[tail_next1]  <= 1'b0;
            dest[tail_next1]  <= bus.dest2;
            regwr[tail_next1] <= bus.regwr2;
         end
         head  <= head + {3'b000, retire_num};
         tail  <= tail + {3'b000, alloc_num};
         count <= count + {4'b0000, alloc_num} - {4'b0000, retire_num};
      end
   end

endmodule

// File: tb/tb_rob_tag_scheduler.sv
// Directed plus random bench for rob_tag_scheduler, checked against a
// queue-of-in-flight-entries reference model.
module tb_rob_tag_scheduler;

   logic clk;
   logic rst;
   rob_tag_scheduler_if bus ();

   rob_tag_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [4:0] tag;
      logic [4:0] dest;
      logic       regwr;
      logic       done;
   } entry_t;

   entry_t rob[$];
   int     mTail;
   int     assertCount = 0;
   int     failCount   = 0;

   task automatic applyStimulus(input logic a1, input logic a2, input logic [4:0] d1,
                                input logic [4:0] d2, input logic w1, input logic w2,
                                input logic h, input logic f, input logic [3:0] wv,
                                input logic [4:0] t0, input logic [4:0] t1,
                                input logic [4:0] t2, input logic [4:0] t3);
      bus.alloc1   = a1;
      bus.alloc2   = a2;
      bus.dest1    = d1;
      bus.dest2    = d2;
      bus.regwr1   = w1;
      bus.regwr2   = w2;
      bus.hold     = h;
      bus.flush    = f;
      bus.wb_valid = wv;
      bus.wb_tag0  = t0;
      bus.wb_tag1  = t1;
      bus.wb_tag2  = t2;
      bus.wb_tag3  = t3;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   // Expected outputs follow from the queue of in-flight entries and current inputs.
   task automatic checkAll();
      logic r1, r2;
      int   sz;
      sz = rob.size();
      r1 = !bus.flush && sz >= 1 && rob[0].done;
      r2 = r1 && sz >= 2 && rob[1].done;
      checkOutput("tag1", bus.tag1, mTail);
      checkOutput("tag2", bus.tag2, (mTail + 1) % 32);
      checkOutput("stall", bus.stall, (bus.hold || sz > 30) ? 1 : 0);
      checkOutput("count", bus.count, sz);
      checkOutput("retire1", bus.retire1, r1);
      checkOutput("retire2", bus.retire2, r2);
      checkOutput("commit1", bus.commit1, (r1 && rob[0].regwr && rob[0].dest != 0) ? 1 : 0);
      checkOutput("commit2", bus.commit2, (r2 && rob[1].regwr && rob[1].dest != 0) ? 1 : 0);
      checkOutput("commit1_addr", bus.commit1_addr, r1 ? rob[0].dest : 0);
      checkOutput("commit2_addr", bus.commit2_addr, r2 ? rob[1].dest : 0);
      checkOutput("commit1_tag", bus.commit1_tag, r1 ? rob[0].tag : 0);
      checkOutput("commit2_tag", bus.commit2_tag, r2 ? rob[1].tag : 0);
   endtask

   function automatic logic [4:0] wbTagOf(input int k);
      case (k)
         0:       return bus.wb_tag0;
         1:       return bus.wb_tag1;
         2:       return bus.wb_tag2;
         default: return bus.wb_tag3;
      endcase
   endfunction

   task automatic modelEdge();
      int   nRet;
      logic stallM;
      entry_t e;
      if (bus.flush) begin
         rob.delete();
         mTail = 0;
         return;
      end
      stallM = bus.hold || rob.size() > 30;
      nRet = 0;
      if (rob.size() >= 1 && rob[0].done) begin
         nRet = 1;
         if (rob.size() >= 2 && rob[1].done) nRet = 2;
      end
      for (int k = 0; k < 4; k++) begin
         if (bus.wb_valid[k]) begin
            for (int i = 0; i < rob.size(); i++) begin
               if (rob[i].tag == wbTagOf(k)) rob[i].done = 1'b1;
            end
         end
      end
      for (int i = 0; i < nRet; i++) void'(rob.pop_front());
      if (!stallM && bus.alloc1) begin
         e.tag = 5'(mTail); e.dest = bus.dest1; e.regwr = bus.regwr1; e.done = 1'b0;
         rob.push_back(e);
         mTail = (mTail + 1) % 32;
         if (bus.alloc2) begin
            e.tag = 5'(mTail); e.dest = bus.dest2; e.regwr = bus.regwr2; e.done = 1'b0;
            rob.push_back(e);
            mTail = (mTail + 1) % 32;
         end
      end
   endtask

   task automatic tick();
      #1;
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic resetDut(input logic h);
      rst = 1'b0;
      applyIdle();
      bus.hold = h;
      rob.delete();
      mTail = 0;
      #2;
      checkAll();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.hold = 1'b0;
   endtask

   // Writes back every in-flight entry until the ROB is empty, bounded in cycles.
   task automatic drain();
      logic [3:0] wv;
      logic [4:0] t [4];
      int n;
      for (int c = 0; c < 40 && rob.size() > 0; c++) begin
         wv = 4'b0000;
         for (int k = 0; k < 4; k++) t[k] = 5'd0;
         n = 0;
         for (int i = 0; i < rob.size() && n < 4; i++) begin
            if (!rob[i].done) begin
               t[n] = rob[i].tag;
               wv[n] = 1'b1;
               n++;
            end
         end
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, wv, t[0], t[1], t[2], t[3]);
         tick();
      end
      applyIdle();
      #1;
      checkOutput("drain_empty", bus.count, 0);
   endtask

   task automatic allocMany(input int n);
      for (int i = 0; i < n; i += 2) begin
         applyStimulus(1, (n - i) >= 2, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
         tick();
      end
      applyIdle();
   endtask

   task automatic randomStep();
      logic [4:0] t [4];
      for (int k = 0; k < 4; k++) begin
         if (rob.size() > 0 && $urandom_range(0, 3) != 0)
            t[k] = rob[$urandom_range(0, rob.size() - 1)].tag;
         else
            t[k] = 5'($urandom_range(0, 31));
      end
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                    ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                    t[0], t[1], t[2], t[3]);
      tick();
   endtask

   initial begin
      rst = 1'b0;
      applyIdle();
      mTail = 0;

      $display("[TB] reset values");
      resetDut(1'b1);
      #1;
      checkOutput("reset_tag2", bus.tag2, 1);

      $display("[TB] dual allocation from reset");
      applyStimulus(1, 1, 5'd3, 5'd4, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
      #1;
      checkOutput("first_tag1", bus.tag1, 0);
      checkOutput("first_tag2", bus.tag2, 1);
      tick();
      applyIdle();
      #1;
      checkOutput("after_alloc_count", bus.count, 2);
      checkOutput("after_alloc_tag1", bus.tag1, 2);
      checkOutput("after_alloc_tag2", bus.tag2, 3);

      $display("[TB] out-of-order writeback retires in order");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'd1, 0, 0, 0);
      tick();
      applyIdle();
      #1;
      checkOutput("no_retire_head_pending", bus.retire1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 5'd0, 0, 0);
      tick();
      applyIdle();
      #1;
      checkOutput("dual_retire1", bus.retire1, 1);
      checkOutput("dual_retire2", bus.retire2, 1);
      checkOutput("dual_commit1_addr", bus.commit1_addr, 3);
      checkOutput("dual_commit2_addr", bus.commit2_addr, 4);
      checkOutput("dual_commit2_tag", bus.commit2_tag, 1);
      tick();
      checkOutput("dual_retire_count", bus.count, 0);

      $display("[TB] fill to 31 entries");
      allocMany(31);
      applyStimulus(1, 1, 5'd7, 5'd8, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
      #1;
      checkOutput("full_stall", bus.stall, 1);
      tick();
      applyIdle();
      #1;
      checkOutput("full_tail_held", bus.tag1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'd2, 0, 0, 0);
      tick();
      applyIdle();
      tick();
      checkOutput("stall_released", bus.stall, 0);
      drain();

      $display("[TB] dest zero never commits");
      applyStimulus(1, 0, 5'd0, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'd1, 0, 0, 0);
      tick();
      applyIdle();
      #1;
      checkOutput("dest0_retire1", bus.retire1, 1);
      checkOutput("dest0_commit1", bus.commit1, 0);
      tick();

      $display("[TB] wrap from tag 30 to 0");
      resetDut(1'b0);
      allocMany(30);
      drain();
      applyStimulus(1, 1, 5'd9, 5'd10, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
      #1;
      checkOutput("wrap_tag1", bus.tag1, 30);
      checkOutput("wrap_tag2", bus.tag2, 31);
      tick();
      checkOutput("wrap_tail", bus.tag1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 5'd30, 5'd31, 0, 0);
      tick();
      applyIdle();
      #1;
      checkOutput("wrap_commit2_tag", bus.commit2_tag, 31);
      tick();
      checkOutput("wrap_head_zero_tag1", bus.tag1, 0);

      $display("[TB] flush with concurrent alloc and writeback");
      allocMany(1);
      drain();
      allocMany(5);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 5'd1, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 5'd5, 5'd6, 1, 1, 0, 1, 4'b0011, 5'd2, 5'd3, 0, 0);
      #1;
      checkOutput("flush_retire_forced", bus.retire1, 0);
      tick();
      checkOutput("flush_count", bus.count, 0);
      checkOutput("flush_tag1", bus.tag1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd0);
      tick();
      applyIdle();
      tick();
      tick();

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) randomStep();
      applyIdle();
      drain();

      $display("[TB] reset mid-operation");
      allocMany(2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 5'(rob[0].tag), 5'(rob[1].tag), 0, 0);
      tick();
      applyIdle();
      rst = 1'b0;
      rob.delete();
      mTail = 0;
      #1;
      checkAll();
      checkOutput("midreset_retire1", bus.retire1, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rob_tag_scheduler.md
ROB_TAG_SCHEDULER -- requirements
Module: rob_tag_scheduler

Interface
REQ-001 SHALL: clk  input  1  clock; all state rising-edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: alloc1, alloc2  input  1 each  dispatch slot requests; slot1 older; alloc2 honoured only with alloc1.
REQ-004 SHALL: dest1, dest2  input  5 each  destination register per slot.
REQ-005 SHALL: regwr1, regwr2  input  1 each  slot writes a register.
REQ-006 SHALL: hold  input  1  front-end pipeline stall; blocks allocation.
REQ-007 SHALL: flush  input  1  discard all in-flight entries.
REQ-008 SHALL: wb_valid  input  4  writeback strobes (alu1, alu2, ld1, ld2).
REQ-009 SHALL: wb_tag0..wb_tag3  input  5 each  completing tag per writeback port.
REQ-010 SHALL: tag1, tag2  output  5 each  tags offered to dispatch slots.
REQ-011 SHALL: stall  output  1  dispatch must not advance (RAT stall input).
REQ-012 SHALL: retire1, retire2  output  1 each  entry leaves ROB this cycle.
REQ-013 SHALL: commit1, commit2  output  1 each  retiring entry updates a register.
REQ-014 SHALL: commit1_addr, commit2_addr, commit1_tag, commit2_tag  output  5 each  retiring dest/tag.
REQ-015 SHALL: count  output  6  occupancy 0..32.

Function
REQ-016 SHALL: 32 entries indexed by tag, each holding valid, done, dest[4:0], regwr; 5-bit head and tail pointers wrap 31->0.
REQ-017 SHALL: tag1 = tail, tag2 = tail+1 mod 32, combinational from registered tail.
REQ-018 SHALL: stall = hold | (count > 30); computed from registered count only (same-cycle retirements do not clear it).
REQ-019 SHALL: on edge with ~stall & ~flush: alloc1 writes entry tail {valid=1, done=0, dest1, regwr1}; alloc1&alloc2 additionally writes tail+1 with dest2/regwr2; tail advances by number allocated (0,1,2).
REQ-020 SHALL: alloc2 without alloc1 allocates nothing.
REQ-021 SHALL: wb_valid[i] sets done of entry wb_tag_i only if that entry is valid; writes to invalid entries ignored; duplicate/simultaneous writebacks to one tag harmless.
REQ-022 SHALL: retire1 = valid&done of head; retire2 = retire1 & valid&done of head+1; in-order, never skip.
REQ-023 SHALL: commitN = retireN & regwr & (dest != 0); commitN_addr = entry dest, commitN_tag = entry index; outputs combinational from registered state.
REQ-024 SHALL: on edge, retired entries cleared (valid=0, done=0), head advances by retire count.
REQ-025 SHALL: count_next = count + allocated - retired; allocation and retirement in same cycle both take effect.
REQ-026 SHALL: writeback at edge n makes retirement visible in cycle n+1 (minimum alloc->retire = 2 cycles).
REQ-027 SHALL: flush synchronous, highest priority: all valid/done cleared, head=tail=0, count=0; alloc and writeback that cycle ignored; retire/commit outputs forced 0 while flush=1.
REQ-028 SHALL: invariant count == (tail - head) mod 32, except count=32 when head==tail with all valid.

Reset
REQ-029 SHALL: rst=0 asynchronously clears all entries, head=tail=0, count=0; outputs: tag1=0, tag2=1, stall=hold, retire*/commit*=0, commit*_addr/tag=0.
REQ-030 SHALL: reset mid-operation discards in-flight entries with no retire/commit pulses.

Verification
REQ-031 SHALL: reset, alloc1&alloc2 dest 3/4 regwr=1 -> tags 0/1, count=2, next tag1=2, tag2=3.
REQ-032 SHALL: wb tag1 only -> no retire (head tag0 not done); then wb tag0 -> next cycle retire1=retire2=1, commit addrs 3/4 tags 0/1, count 0.
REQ-033 SHALL: 31 entries allocated -> stall=1, alloc ignored, tail unchanged; one retirement -> stall=0 next cycle.
REQ-034 SHALL: dest=0 regwr=1 entry done -> retire1=1, commit1=0.
REQ-035 SHALL: head=30 tail=30, dual alloc -> tags 30/31, tail=0; then retire through wrap with head 31->0.
REQ-036 SHALL: 5 entries in flight, flush with simultaneous alloc and wb -> count=0, head=tail=0, no retire pulses, later wb to old tags ignored.
